// File: rtl/priority_arbiter_4_if.sv
// Request/grant bundle between the requesting blocks and priority_arbiter_4.
// The master side raises requests; the slave side (the arbiter) returns the
// one-hot grant, its encoded index, a valid flag and the forced-release pulse.
interface priority_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       hold_timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  hold_timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output hold_timeout
  );
endinterface

// File: rtl/priority_arbiter_4.sv
// Four-requester arbiter with registered grant, no pre-emption, and a hold
// limit of MAX_HOLD cycles per grant. Default order is 3 > 2 > 1 > 0.
// Optional macro PRIO_ARB_ROUND_ROBIN_EN rotates the order behind the most
// recent winner (pointer 'last'); otherwise the order is fixed.
module priority_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input logic                 clk,
  input logic                 rst,
  priority_arbiter_4_if.slave bus
);

  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    GRANT = 1'b1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

  logic [0:0]    state;
  logic [3:0]    grant_q;
  logic [1:0]    idx_q;
  logic          timeout_q;
  logic [CW-1:0] count;

  logic [1:0] base;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
  logic [1:0] last;
  assign base = last;
`else
  assign base = 2'd0;
`endif

  // Search base-1, base-2, base-3, base (mod 4); the nearest hit wins, so the
  // loop runs from lowest to highest priority and lets later hits overwrite.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] b);
    logic [1:0] w;
    logic [1:0] c;
    w = b;
    for (int k = 4; k >= 1; k--) begin
      c = b - k[1:0];
      if (r[c]) w = c;
    end
    return w;
  endfunction

  logic       owner_req;
  logic       release_now;
  logic       timeout_now;
  logic       start_grant;
  logic [3:0] others;
  logic [1:0] winner;

  // Decide whether a new grant is issued at the next edge, and to whom.
  always_comb begin
    owner_req   = bus.req[idx_q];
    release_now = (state == GRANT) && !owner_req;
    timeout_now = (state == GRANT) && owner_req && (count == LIMIT);
    others      = bus.req & ~grant_q;
    winner      = (timeout_now && (others == 4'b0)) ? idx_q : pick(others, base);
    if (state == IDLE) begin
      start_grant = (bus.req != 4'b0);
    end else begin
      start_grant = (release_now && (others != 4'b0)) || timeout_now;
    end
  end

  // State, grant registers and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= 4'b0;
      idx_q     <= 2'd0;
      timeout_q <= 1'b0;
      count     <= '0;
    end else if (start_grant) begin
      state     <= GRANT;
      grant_q   <= 4'b0001 << winner;
      idx_q     <= winner;
      timeout_q <= timeout_now;
      count     <= '0;
    end else if (release_now) begin
      state     <= IDLE;
      grant_q   <= 4'b0;
      idx_q     <= 2'd0;
      timeout_q <= 1'b0;
      count     <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (state == GRANT) count <= count + 1'b1;
    end
  end

`ifdef PRIO_ARB_ROUND_ROBIN_EN
  // Remember the most recent winner so the next search starts just below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 2'd0;
    end else if (start_grant) begin
      last <= winner;
    end
  end
`endif

  assign bus.grant        = grant_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_valid  = (state == GRANT);
  assign bus.hold_timeout = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_4.sv
// Testbench for priority_arbiter_4: two instances (MAX_HOLD 15 and 2) share
// one request stream; a per-instance behavioural model predicts every output.
module tb_priority_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  priority_arbiter_4_if bus_a ();
  priority_arbiter_4_if bus_b ();
  assign bus_a.req = req;
  assign bus_b.req = req;

  priority_arbiter_4 #(.MAX_HOLD(15), .CW(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  priority_arbiter_4 #(.MAX_HOLD(2),  .CW(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  // Model state per instance: owner (-1 when idle), cycles the grant has been
  // visible, and whether the current grant came from a forced release.
  int m_owner[2];
  int m_held[2];
  bit m_pulse[2];
  int maxh[2] = '{15, 2};
`ifdef PRIO_ARB_ROUND_ROBIN_EN
  int m_last[2];

  function automatic int pickRr(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last - k + 8) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction
`else
  function automatic int pickFixed(input logic [3:0] r);
    for (int c = 3; c >= 0; c--) if (r[c]) return c;
    return -1;
  endfunction
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rs, input int n);
    req = r;
    rst = rs;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compareInst(input int i, input logic [3:0] g, input logic [1:0] gi,
                             input logic gv, input logic ht);
    int eg, ei, ev;
    eg = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
    ei = (m_owner[i] >= 0) ? m_owner[i] : 0;
    ev = (m_owner[i] >= 0) ? 1 : 0;
    checkOutput(i == 0 ? "a_grant" : "b_grant", int'(g), eg);
    checkOutput(i == 0 ? "a_grant_idx" : "b_grant_idx", int'(gi), ei);
    checkOutput(i == 0 ? "a_grant_valid" : "b_grant_valid", int'(gv), ev);
    checkOutput(i == 0 ? "a_hold_timeout" : "b_hold_timeout", int'(ht), int'(m_pulse[i]));
  endtask

  // Advance one model by the edge that is about to sample req/rst.
  task automatic stepModel(input int i);
    logic [3:0] cand;
    bit do_grant;
    bit forced;
    int w;
    do_grant = 1'b0;
    forced   = 1'b0;
    cand     = req;
    if (rst) begin
      m_owner[i] = -1;
      m_held[i]  = 0;
      m_pulse[i] = 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
      m_last[i] = 0;
`endif
      return;
    end
    if (m_owner[i] < 0) begin
      do_grant = (req != 4'b0);
    end else if (!req[m_owner[i]]) begin
      do_grant = (req != 4'b0);
      if (!do_grant) m_owner[i] = -1;
    end else if (m_held[i] == maxh[i]) begin
      cand[m_owner[i]] = 1'b0;
      do_grant = 1'b1;
      forced   = 1'b1;
    end else begin
      m_held[i]++;
    end
    if (do_grant) begin
      if (cand == 4'b0) begin
        w = m_owner[i];
      end else begin
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        w = pickRr(cand, m_last[i]);
`else
        w = pickFixed(cand);
`endif
      end
      m_owner[i] = w;
      m_held[i]  = 1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
      m_last[i] = w;
`endif
    end
    m_pulse[i] = forced;
  endtask

  // Every cycle: compare both DUTs to the model, then step the model.
  always @(negedge clk) begin
    if (armed) begin
      compareInst(0, bus_a.grant, bus_a.grant_idx, bus_a.grant_valid, bus_a.hold_timeout);
      compareInst(1, bus_b.grant, bus_b.grant_idx, bus_b.grant_valid, bus_b.hold_timeout);
    end
    for (int i = 0; i < 2; i++) stepModel(i);
    if (rst) armed = 1'b1;
  end

  int exp_seq[10];

  initial begin
    int n;
    int bad;
    int pulses;
    int first;
    int second;
    logic [3:0] r;
    logic rs;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    exp_seq = '{3, 3, 2, 2, 1, 1, 0, 0, 3, 3};
`else
    exp_seq = '{3, 3, 2, 2, 3, 3, 2, 2, 3, 3};
`endif

    // Reset with every request asserted.
    applyStimulus(4'b1111, 1'b1, 3);
    checkOutput("reset_grant", int'(bus_a.grant), 0);
    checkOutput("reset_idx", int'(bus_a.grant_idx), 0);
    checkOutput("reset_valid", int'(bus_a.grant_valid), 0);
    checkOutput("reset_timeout", int'(bus_a.hold_timeout), 0);

    // One-cycle latency, highest pending wins.
    applyStimulus(4'b0101, 1'b0, 1);
    checkOutput("latency_grant", int'(bus_a.grant), 4);
    checkOutput("latency_idx", int'(bus_a.grant_idx), 2);
    checkOutput("latency_valid", int'(bus_a.grant_valid), 1);

    // No pre-emption, then bubble-free hand-off.
    applyStimulus(4'b1100, 1'b0, 5);
    checkOutput("no_preempt_grant", int'(bus_a.grant), 4);
    applyStimulus(4'b1000, 1'b0, 1);
    checkOutput("handoff_grant", int'(bus_a.grant), 8);
    checkOutput("handoff_timeout", int'(bus_a.hold_timeout), 0);

    // Timeout hand-off from 1 to 0 after 15 cycles.
    applyStimulus(4'b0000, 1'b0, 2);
    applyStimulus(4'b0011, 1'b0, 1);
    n = 0;
    while (bus_a.grant == 4'b0010 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("hold_length", n, 15);
    checkOutput("timeout_grant", int'(bus_a.grant), 1);
    checkOutput("timeout_pulse", int'(bus_a.hold_timeout), 1);
    applyStimulus(4'b0011, 1'b0, 1);
    checkOutput("timeout_pulse_width", int'(bus_a.hold_timeout), 0);

    // Sole requester is re-granted, pulsing every 15 cycles.
    applyStimulus(4'b0000, 1'b0, 2);
    applyStimulus(4'b0001, 1'b0, 1);
    bad = 0; pulses = 0; first = 0; second = 0;
    for (int i = 2; i <= 41; i++) begin
      applyStimulus(4'b0001, 1'b0, 1);
      if (bus_a.grant != 4'b0001) bad++;
      if (bus_a.hold_timeout) begin
        pulses++;
        if (pulses == 1) first = i;
        if (pulses == 2) second = i;
      end
    end
    checkOutput("solo_grant_drops", bad, 0);
    checkOutput("solo_pulses", pulses, 2);
    checkOutput("solo_first_pulse", first, 16);
    checkOutput("solo_pulse_gap", second - first, 15);

    // Mid-grant reset, then return one cycle after release of reset.
    applyStimulus(4'b0001, 1'b1, 1);
    checkOutput("midrst_grant", int'(bus_a.grant), 0);
    checkOutput("midrst_valid", int'(bus_a.grant_valid), 0);
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("midrst_regrant", int'(bus_a.grant), 1);

    // Grant order with MAX_HOLD=2 and all requests held.
    applyStimulus(4'b0000, 1'b1, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1111, 1'b0, 1);
      checkOutput("order_seq", int'(bus_b.grant_idx), exp_seq[i]);
    end

    // Randomised traffic with occasional resets.
    r = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 63) == 0);
      applyStimulus(r, rs, 1);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
